// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch controller and its neighbours:
// divider strobes and conditioned controls in, BCD time and scan outputs back.
interface stopwatch_ctrl_if;
    logic       tick_1hz;
    logic       tick_2hz;
    logic       tick_fst;
    logic       blink;
    logic       pause_btn;
    logic       clear_btn;
    logic       adj;
    logic       sel;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] an;
    logic [3:0] digit;
    logic       running;

    modport master (
        output tick_1hz, tick_2hz, tick_fst, blink,
        output pause_btn, clear_btn, adj, sel,
        input  min_tens, min_ones, sec_tens, sec_ones,
        input  an, digit, running
    );

    modport slave (
        input  tick_1hz, tick_2hz, tick_fst, blink,
        input  pause_btn, clear_btn, adj, sel,
        output min_tens, min_ones, sec_tens, sec_ones,
        output an, digit, running
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch sequencer: run/pause/clear/adjust FSM, BCD time keeping,
// and four-digit multiplexed display select with field blanking in adjust.
module stopwatch_ctrl #(
    parameter int MAX_MIN = 59
) (
    input  logic             clk,
    input  logic             rst,
    stopwatch_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, ADJUST} state_t;

    localparam logic [3:0] MAX_MIN_T = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_MIN_O = 4'(MAX_MIN % 10);

    state_t     state, state_nxt;
    logic       running_r;

    logic       pause_q, pause_prev, clear_q, clear_prev;
    logic       pause_edge, clear_edge;

    logic [3:0] min_t, min_o, sec_t, sec_o;
    logic [3:0] min_t_nxt, min_o_nxt, sec_t_nxt, sec_o_nxt;
    logic       sec_inc, min_inc;
    logic       sec_at_max, min_at_max;

    logic [1:0] scan_idx;
    logic [3:0] an_r, digit_r;
    logic [3:0] an_nxt, digit_nxt;

    // Button levels are captured then compared with their previous sample,
    // so an edge becomes visible one cycle after the input rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pause_q    <= 1'b0;
            pause_prev <= 1'b0;
            clear_q    <= 1'b0;
            clear_prev <= 1'b0;
        end else begin
            pause_q    <= bus.pause_btn;
            pause_prev <= pause_q;
            clear_q    <= bus.clear_btn;
            clear_prev <= clear_q;
        end
    end

    assign pause_edge = pause_q & ~pause_prev;
    assign clear_edge = clear_q & ~clear_prev;

    // State register; running is registered alongside the state it mirrors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            running_r <= 1'b0;
        end else begin
            state     <= state_nxt;
            running_r <= (state_nxt == RUN);
        end
    end

    // Next state: clear edge, then adj level, then pause edge.
    always_comb begin
        state_nxt = state;
        if (clear_edge) begin
            state_nxt = bus.adj ? ADJUST : IDLE;
        end else if (bus.adj) begin
            state_nxt = ADJUST;
        end else if (state == ADJUST) begin
            state_nxt = PAUSE;
        end else if (pause_edge) begin
            case (state)
                IDLE:    state_nxt = RUN;
                RUN:     state_nxt = PAUSE;
                PAUSE:   state_nxt = RUN;
                default: state_nxt = state;
            endcase
        end
    end

    assign sec_at_max = (sec_t == 4'd5) && (sec_o == 4'd9);
    assign min_at_max = (min_t == MAX_MIN_T) && (min_o == MAX_MIN_O);

    // Next time value: clear wins over any tick; the seconds-to-minutes carry
    // exists only in RUN, while adjust steps one field independently.
    always_comb begin
        sec_inc   = 1'b0;
        min_inc   = 1'b0;
        min_t_nxt = min_t;
        min_o_nxt = min_o;
        sec_t_nxt = sec_t;
        sec_o_nxt = sec_o;

        if (!clear_edge) begin
            if (state == RUN && bus.tick_1hz) begin
                sec_inc = 1'b1;
                min_inc = sec_at_max;
            end else if (state == ADJUST && bus.tick_2hz) begin
                sec_inc = bus.sel;
                min_inc = ~bus.sel;
            end
        end

        if (clear_edge) begin
            min_t_nxt = '0;
            min_o_nxt = '0;
            sec_t_nxt = '0;
            sec_o_nxt = '0;
        end else begin
            if (sec_inc) begin
                if (sec_o == 4'd9) begin
                    sec_o_nxt = '0;
                    sec_t_nxt = (sec_t == 4'd5) ? 4'd0 : sec_t + 4'd1;
                end else begin
                    sec_o_nxt = sec_o + 4'd1;
                end
            end
            if (min_inc) begin
                if (min_at_max) begin
                    min_t_nxt = '0;
                    min_o_nxt = '0;
                end else if (min_o == 4'd9) begin
                    min_o_nxt = '0;
                    min_t_nxt = min_t + 4'd1;
                end else begin
                    min_o_nxt = min_o + 4'd1;
                end
            end
        end
    end

    // Time digit registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_t <= '0;
            min_o <= '0;
            sec_t <= '0;
            sec_o <= '0;
        end else begin
            min_t <= min_t_nxt;
            min_o <= min_o_nxt;
            sec_t <= sec_t_nxt;
            sec_o <= sec_o_nxt;
        end
    end

    // Digit enable and value for the current scan slot; the selected field
    // is blanked during the blank phase of blink while adjusting.
    always_comb begin
        an_nxt    = 4'b1110;
        digit_nxt = sec_o;
        case (scan_idx)
            2'd0: begin an_nxt = 4'b1110; digit_nxt = sec_o; end
            2'd1: begin an_nxt = 4'b1101; digit_nxt = sec_t; end
            2'd2: begin an_nxt = 4'b1011; digit_nxt = min_o; end
            default: begin an_nxt = 4'b0111; digit_nxt = min_t; end
        endcase
        if (state == ADJUST && bus.blink && (scan_idx[1] == ~bus.sel)) begin
            an_nxt = '1;
        end
    end

    // Scan index and registered display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_idx <= '0;
            an_r     <= 4'b1110;
            digit_r  <= '0;
        end else begin
            if (bus.tick_fst) begin
                scan_idx <= scan_idx + 2'd1;
            end
            an_r    <= an_nxt;
            digit_r <= digit_nxt;
        end
    end

    assign bus.min_tens = min_t;
    assign bus.min_ones = min_o;
    assign bus.sec_tens = sec_t;
    assign bus.sec_ones = sec_o;
    assign bus.an       = an_r;
    assign bus.digit    = digit_r;
    assign bus.running  = running_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus random
// stimulus, compared every cycle against a minutes/seconds reference model.
module tb_stopwatch_ctrl;

    localparam int MAX_MIN = 59;

    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_ADJ} mstate_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    stopwatch_ctrl_if bus ();

    stopwatch_ctrl #(.MAX_MIN(MAX_MIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    mstate_t    m_st;
    int         m_min, m_sec, m_idx;
    bit         m_pq, m_pp, m_cq, m_cp;
    logic [3:0] m_an, m_digit;
    bit         m_run;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [15:0] bcd_time(input int mn, input int sc);
        return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    function automatic logic [15:0] dut_time();
        return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_min = 0; m_sec = 0; m_idx = 0;
        m_pq = 0; m_pp = 0; m_cq = 0; m_cp = 0;
        m_an = 4'b1110; m_digit = 4'd0; m_run = 0;
    endtask

    // One clock edge of the reference, using the inputs held during the cycle.
    task automatic model_step();
        bit pe, ce;
        int total;
        mstate_t nst;
        pe = m_pq && !m_pp;
        ce = m_cq && !m_cp;

        m_an = ~(4'b0001 << m_idx);
        if (m_st == M_ADJ && bus.blink && ((m_idx >= 2) == (bus.sel == 1'b0))) m_an = 4'b1111;
        case (m_idx)
            0: m_digit = 4'(m_sec % 10);
            1: m_digit = 4'(m_sec / 10);
            2: m_digit = 4'(m_min % 10);
            default: m_digit = 4'(m_min / 10);
        endcase
        if (bus.tick_fst) m_idx = (m_idx + 1) % 4;

        if (ce) begin
            m_min = 0; m_sec = 0;
        end else if (m_st == M_RUN && bus.tick_1hz) begin
            total = m_min * 60 + m_sec + 1;
            m_sec = total % 60;
            m_min = (total / 60) % (MAX_MIN + 1);
        end else if (m_st == M_ADJ && bus.tick_2hz) begin
            if (bus.sel) m_sec = (m_sec + 1) % 60;
            else         m_min = (m_min + 1) % (MAX_MIN + 1);
        end

        nst = m_st;
        if (ce)                nst = bus.adj ? M_ADJ : M_IDLE;
        else if (bus.adj)      nst = M_ADJ;
        else if (m_st == M_ADJ) nst = M_PAUSE;
        else if (pe)           nst = (m_st == M_RUN) ? M_PAUSE : M_RUN;
        m_st  = nst;
        m_run = (nst == M_RUN);

        m_pp = m_pq; m_pq = bus.pause_btn;
        m_cp = m_cq; m_cq = bus.clear_btn;
    endtask

    task automatic compare_all();
        check("time",    32'(dut_time()),    32'(bcd_time(m_min, m_sec)));
        check("an",      32'(bus.an),        32'(m_an));
        check("digit",   32'(bus.digit),     32'(m_digit));
        check("running", 32'(bus.running),   32'(m_run));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic press_pause();
        bus.pause_btn = 1'b1; cycle();
        bus.pause_btn = 1'b0; cycle(); cycle();
    endtask

    task automatic pulse_1hz(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick_1hz = 1'b1; cycle();
            bus.tick_1hz = 1'b0; cycle();
        end
    endtask

    task automatic pulse_2hz(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick_2hz = 1'b1; cycle();
            bus.tick_2hz = 1'b0; cycle();
        end
    endtask

    task automatic pulse_fst();
        bus.tick_fst = 1'b1; cycle();
        bus.tick_fst = 1'b0; cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("rst_time", 32'(dut_time()), 32'h0);
        check("rst_an",   32'(bus.an), 32'hE);
        check("rst_run",  32'(bus.running), 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.tick_1hz = 0; bus.tick_2hz = 0; bus.tick_fst = 0; bus.blink = 0;
        bus.pause_btn = 0; bus.clear_btn = 0; bus.adj = 0; bus.sel = 0;
        model_reset();
        do_reset();

        // Start, 61 seconds, display scan order
        press_pause();
        check("start_run", 32'(bus.running), 32'h1);
        pulse_1hz(61);
        check("t_0101", 32'(dut_time()), 32'h0101);
        pulse_fst(); check("scan1", 32'(bus.an), 32'hD);
        pulse_fst(); check("scan2", 32'(bus.an), 32'hB);
        pulse_fst(); check("scan3", 32'(bus.an), 32'h7);
        pulse_fst(); check("scan0", 32'(bus.an), 32'hE);

        // Preload 59:58 via adjust, then full wrap while running
        bus.adj = 1; bus.sel = 0; cycle();
        pulse_2hz(58);
        bus.sel = 1;
        pulse_2hz(57);
        check("pre_5958", 32'(dut_time()), 32'h5958);
        bus.adj = 0; cycle();
        check("adj_exit_pause", 32'(bus.running), 32'h0);
        press_pause();
        pulse_1hz(1); check("wrap_5959", 32'(dut_time()), 32'h5959);
        pulse_1hz(1); check("wrap_0000", 32'(dut_time()), 32'h0000);
        pulse_1hz(1); check("wrap_0001", 32'(dut_time()), 32'h0001);
        check("wrap_run", 32'(bus.running), 32'h1);

        // Pause holds time, resume continues
        pulse_1hz(9);
        press_pause();
        pulse_1hz(5);
        check("paused_0010", 32'(dut_time()), 32'h0010);
        check("paused_run",  32'(bus.running), 32'h0);
        press_pause();
        pulse_1hz(1);
        check("resume_0011", 32'(dut_time()), 32'h0011);

        // Seconds adjust wraps without touching minutes; blanking
        bus.adj = 1; bus.sel = 1; cycle();
        pulse_2hz(47);
        pulse_2hz(1); check("adj_0059", 32'(dut_time()), 32'h0059);
        pulse_2hz(1); check("adj_0000", 32'(dut_time()), 32'h0000);
        pulse_2hz(1); check("adj_0001", 32'(dut_time()), 32'h0001);
        bus.blink = 1; cycle();
        check("blank_idx0", 32'(bus.an), 32'hF);
        pulse_fst(); check("blank_idx1", 32'(bus.an), 32'hF);
        pulse_fst(); check("noblank_idx2", 32'(bus.an), 32'hB);
        bus.blink = 0;

        // Clear edge coincident with a 1 Hz tick at 12:34
        pulse_2hz(33);
        bus.sel = 0;
        pulse_2hz(12);
        check("pre_1234", 32'(dut_time()), 32'h1234);
        bus.adj = 0; cycle();
        press_pause();
        check("run_1234", 32'(bus.running), 32'h1);
        bus.clear_btn = 1; cycle();
        bus.clear_btn = 0; bus.tick_1hz = 1; cycle();
        bus.tick_1hz = 0;
        check("clr_time", 32'(dut_time()), 32'h0000);
        check("clr_run",  32'(bus.running), 32'h0);
        pulse_1hz(2);
        check("idle_hold", 32'(dut_time()), 32'h0000);

        // Asynchronous reset mid-run at 03:07
        press_pause();
        pulse_1hz(187);
        check("pre_0307", 32'(dut_time()), 32'h0307);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check("arst_time", 32'(dut_time()), 32'h0);
        check("arst_an",   32'(bus.an), 32'hE);
        check("arst_run",  32'(bus.running), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        pulse_1hz(3);
        check("post_rst_idle", 32'(dut_time()), 32'h0);
        press_pause();
        pulse_1hz(1);
        check("post_rst_0001", 32'(dut_time()), 32'h0001);

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            bus.tick_1hz = ($urandom_range(0, 2) == 0);
            bus.tick_2hz = ($urandom_range(0, 2) == 0);
            bus.tick_fst = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 15) == 0) bus.blink     = ~bus.blink;
            if ($urandom_range(0, 9)  == 0) bus.pause_btn = ~bus.pause_btn;
            if ($urandom_range(0, 79) == 0) bus.clear_btn = ~bus.clear_btn;
            if ($urandom_range(0, 99) == 0) bus.adj       = ~bus.adj;
            if ($urandom_range(0, 19) == 0) bus.sel       = ~bus.sel;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
